// File: rtl/mips_run_ctrl.sv
// -----------------------------------------------------------------------------
// mips_run_ctrl
//
// Run controller for the MIPS core. After a start pulse it holds the core in
// reset for RESET_HOLD cycles, then enables execution and counts RUN cycles
// until the run ends by an explicit halt request, a PC self-loop (the "j ."
// idiom, seen as HALT_REPEAT consecutive valid samples of the same PC), or
// the MAX_CYCLES watchdog. The PC at the end of the run is latched.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst_n        synchronous active-low reset
//   start        one-cycle pulse, begins a run (ignored in HOLD and RUN)
//   pc           current core PC
//   pc_valid     pc is meaningful this cycle
//   halt_req     explicit halt from core or testbench
//   core_rst_n   reset to the core, active low
//   core_en      core clock / step enable
//   running      high while in RUN
//   done         sticky, run ended by halt or self-loop
//   timeout      sticky, run ended by watchdog
//   cycle_count  RUN cycles elapsed in the current/last run
//   final_pc     PC latched at the end of the run
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module mips_run_ctrl #(
  parameter int PC_W        = 32,
  parameter int RESET_HOLD  = 4,
  parameter int MAX_CYCLES  = 1000,
  parameter int HALT_REPEAT = 3,
  parameter int CNT_W       = $clog2(MAX_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  input  logic             pc_valid,
  input  logic             halt_req,
  output logic             core_rst_n,
  output logic             core_en,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [PC_W-1:0]  final_pc
);

  localparam int HOLD_W = $clog2(RESET_HOLD + 1);
  localparam int REP_W  = $clog2(HALT_REPEAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_e;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
  logic [PC_W-1:0]   last_pc_q, last_pc_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
  logic [PC_W-1:0]   final_pc_q, final_pc_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              core_en_q, core_en_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;

  logic              enter_hold;
  logic              loop_halt;

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    rep_cnt_d     = rep_cnt_q;
    last_pc_d     = last_pc_q;
    cycle_count_d = cycle_count_q;
    final_pc_d    = final_pc_q;
    core_rst_n_d  = core_rst_n_q;
    core_en_d     = core_en_q;
    running_d     = running_q;
    done_d        = done_q;
    timeout_d     = timeout_q;
    enter_hold    = 1'b0;
    loop_halt     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        core_rst_n_d = 1'b0;
        core_en_d    = 1'b0;
        running_d    = 1'b0;
        enter_hold   = start;
      end

      S_HOLD: begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        if (hold_cnt_q == HOLD_W'(RESET_HOLD - 1)) begin
          state_d      = S_RUN;
          core_rst_n_d = 1'b1;
          core_en_d    = 1'b1;
          running_d    = 1'b1;
        end
      end

      S_RUN: begin
        cycle_count_d = cycle_count_q + CNT_W'(1);

        // rep_cnt is 0 only before the first valid sample of a run, so that
        // sample starts a fresh streak even if it equals the cleared last_pc.
        if (pc_valid) begin
          last_pc_d = pc;
          if (rep_cnt_q != '0 && pc == last_pc_q) begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
          end else begin
            rep_cnt_d = REP_W'(1);
          end
          loop_halt = (rep_cnt_d == REP_W'(HALT_REPEAT));
        end

        // last_pc_d already holds pc when it is valid, else the last valid
        // sample; it is the PC to report in both end cases. Halt has
        // priority over the watchdog.
        if (halt_req || loop_halt) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          final_pc_d = last_pc_d;
          core_en_d  = 1'b0;
          running_d  = 1'b0;
        end else if (cycle_count_q == CNT_W'(MAX_CYCLES - 1)) begin
          state_d    = S_TIMEOUT;
          timeout_d  = 1'b1;
          final_pc_d = last_pc_d;
          core_en_d  = 1'b0;
          running_d  = 1'b0;
        end
      end

      S_DONE, S_TIMEOUT: begin
        // core_rst_n stays high so the halted core can still be inspected.
        enter_hold = start;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (enter_hold) begin
      state_d       = S_HOLD;
      hold_cnt_d    = '0;
      rep_cnt_d     = '0;
      last_pc_d     = '0;
      cycle_count_d = '0;
      core_rst_n_d  = 1'b0;
      core_en_d     = 1'b0;
      running_d     = 1'b0;
      done_d        = 1'b0;
      timeout_d     = 1'b0;
    end
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch and is
  // only seen at a rising edge; state uses non-blocking assignments so every
  // flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      hold_cnt_q    <= '0;
      rep_cnt_q     <= '0;
      last_pc_q     <= '0;
      cycle_count_q <= '0;
      final_pc_q    <= '0;
      core_rst_n_q  <= 1'b0;
      core_en_q     <= 1'b0;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      rep_cnt_q     <= rep_cnt_d;
      last_pc_q     <= last_pc_d;
      cycle_count_q <= cycle_count_d;
      final_pc_q    <= final_pc_d;
      core_rst_n_q  <= core_rst_n_d;
      core_en_q     <= core_en_d;
      running_q     <= running_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
    end
  end

  assign core_rst_n  = core_rst_n_q;
  assign core_en     = core_en_q;
  assign running     = running_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_count_q;
  assign final_pc    = final_pc_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_run_ctrl
//
// Self-checking bench for mips_run_ctrl. Each run queues per-cycle stimulus
// and pushes the expected end-of-run result to a scoreboard; when the DUT
// raises done or timeout the expectation is popped and compared.
// -----------------------------------------------------------------------------
module tb_mips_run_ctrl;

  localparam int PC_W        = 32;
  localparam int RESET_HOLD  = 4;
  localparam int MAX_CYCLES  = 20;
  localparam int HALT_REPEAT = 3;
  localparam int CNT_W       = $clog2(MAX_CYCLES + 1);

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [PC_W-1:0]  pc;
  logic             pc_valid;
  logic             halt_req;
  logic             core_rst_n;
  logic             core_en;
  logic             running;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;
  logic [PC_W-1:0]  final_pc;

  mips_run_ctrl #(
    .PC_W        (PC_W),
    .RESET_HOLD  (RESET_HOLD),
    .MAX_CYCLES  (MAX_CYCLES),
    .HALT_REPEAT (HALT_REPEAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .halt_req    (halt_req),
    .core_rst_n  (core_rst_n),
    .core_en     (core_en),
    .running     (running),
    .done        (done),
    .timeout     (timeout),
    .cycle_count (cycle_count),
    .final_pc    (final_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic            valid;
    logic            halt;
    logic            start;
  } stim_t;

  typedef struct {
    logic            done;
    logic            timeout;
    int              count;
    logic [PC_W-1:0] final_pc;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start    = 1'b0;
    pc       = '0;
    pc_valid = 1'b0;
    halt_req = 1'b0;
  endtask

  task automatic push_stim(input logic [PC_W-1:0] p, input logic v, input logic h, input logic s);
    stim_t st;
    st.pc    = p;
    st.valid = v;
    st.halt  = h;
    st.start = s;
    stim_q.push_back(st);
  endtask

  task automatic push_exp(input logic d, input logic t, input int c, input logic [PC_W-1:0] f);
    exp_t e;
    e.done     = d;
    e.timeout  = t;
    e.count    = c;
    e.final_pc = f;
    exp_q.push_back(e);
  endtask

  // Pulse start and walk through HOLD; optionally re-pulse start mid-HOLD,
  // which must not stretch the reset window.
  task automatic start_run(input string name, input bit poke_hold);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({name, "_hold_done_clr"}, done, 1'b0);
    check({name, "_hold_tmo_clr"}, timeout, 1'b0);
    for (int i = 0; i < RESET_HOLD; i++) begin
      check({name, "_hold_core_rst_n"}, core_rst_n, 1'b0);
      check({name, "_hold_core_en"}, core_en, 1'b0);
      if (poke_hold && i == 1) start = 1'b1;
      tick();
      start = 1'b0;
    end
    check({name, "_run_core_rst_n"}, core_rst_n, 1'b1);
    check({name, "_run_running"}, running, 1'b1);
    check({name, "_run_count0"}, cycle_count, 0);
  endtask

  // Drive queued RUN stimulus until the DUT ends the run (bounded), then
  // pop the scoreboard and compare.
  task automatic run_and_score(input string name);
    bit          ended;
    int          budget;
    stim_t       s;
    exp_t        e;
    logic [CNT_W-1:0] cnt_end;
    ended  = 1'b0;
    budget = stim_q.size() + 2;
    while (!ended && budget > 0) begin
      if (stim_q.size() > 0) begin
        s = stim_q.pop_front();
      end else begin
        s.pc = '0; s.valid = 1'b0; s.halt = 1'b0; s.start = 1'b0;
      end
      pc       = s.pc;
      pc_valid = s.valid;
      halt_req = s.halt;
      start    = s.start;
      tick();
      budget--;
      if (done || timeout) ended = 1'b1;
      else check({name, "_core_en_run"}, core_en, 1'b1);
    end
    idle_inputs();
    stim_q.delete();
    if (!ended) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_end: run did not end, expected done or timeout", name);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_sb: DUT ended a run with no expectation queued", name);
    end else begin
      e = exp_q.pop_front();
      check({name, "_done"}, done, e.done);
      check({name, "_timeout"}, timeout, e.timeout);
      check({name, "_count"}, cycle_count, e.count);
      check({name, "_final_pc"}, final_pc, e.final_pc);
      check({name, "_core_en_off"}, core_en, 1'b0);
      check({name, "_running_off"}, running, 1'b0);
      check({name, "_core_rst_n_hi"}, core_rst_n, 1'b1);
      cnt_end = cycle_count;
      tick();
      check({name, "_sticky_done"}, done, e.done);
      check({name, "_sticky_tmo"}, timeout, e.timeout);
      check({name, "_frozen_count"}, cycle_count, cnt_end);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // Reset with start held high: reset dominates.
    start = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("rst_core_rst_n", core_rst_n, 1'b0);
    check("rst_core_en", core_en, 1'b0);
    check("rst_running", running, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_count", cycle_count, 0);
    check("rst_final_pc", final_pc, 0);
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < RESET_HOLD + 2; i++) tick();
    check("idle_core_rst_n", core_rst_n, 1'b0);
    check("idle_running", running, 1'b0);

    // Nominal self-loop: 0,4,8,C,C,C.
    start_run("nominal", 1'b0);
    push_stim(32'h00, 1, 0, 0);
    push_stim(32'h04, 1, 0, 0);
    push_stim(32'h08, 1, 0, 0);
    push_stim(32'h0C, 1, 0, 0);
    push_stim(32'h0C, 1, 0, 0);
    push_stim(32'h0C, 1, 0, 0);
    push_exp(1, 0, 6, 32'h0C);
    run_and_score("nominal");

    // Re-run from DONE; halt_req with invalid PC on RUN cycle 10.
    start_run("halt_inv", 1'b0);
    for (int c = 1; c <= 9; c++) push_stim(32'h100 + 4 * (c - 1), 1, 0, 0);
    push_stim(32'hDEAD, 0, 1, 0);
    push_exp(1, 0, 10, 32'h120);
    run_and_score("halt_inv");

    // Self-loop streak held across an invalid sample, restarted by a PC change.
    start_run("loop_gap", 1'b0);
    push_stim(32'h40, 1, 0, 0);
    push_stim(32'h40, 1, 0, 0);
    push_stim(32'h99, 0, 0, 0);
    push_stim(32'h44, 1, 0, 0);
    push_stim(32'h44, 1, 0, 0);
    push_stim(32'h44, 1, 0, 0);
    push_exp(1, 0, 6, 32'h44);
    run_and_score("loop_gap");

    // Watchdog: PC advances every cycle, never loops.
    start_run("watchdog", 1'b0);
    for (int i = 0; i < MAX_CYCLES + 5; i++) push_stim(32'h200 + 4 * i, 1, 0, 0);
    push_exp(0, 1, MAX_CYCLES, 32'h200 + 4 * (MAX_CYCLES - 1));
    run_and_score("watchdog");

    // Halt on the last RUN cycle wins over timeout; re-run from TIMEOUT.
    start_run("simul", 1'b0);
    for (int i = 0; i < MAX_CYCLES; i++)
      push_stim(32'h300 + 4 * i, 1, (i == MAX_CYCLES - 1), 0);
    push_exp(1, 0, MAX_CYCLES, 32'h300 + 4 * (MAX_CYCLES - 1));
    run_and_score("simul");

    // Start pulses in HOLD and RUN are ignored; reset during RUN cycle 5.
    start_run("midrst", 1'b1);
    for (int c = 1; c <= 4; c++) begin
      pc       = 32'h500 + 4 * c;
      pc_valid = 1'b1;
      start    = (c == 2);
      tick();
      check("midrst_count", cycle_count, c);
      check("midrst_running", running, 1'b1);
    end
    start    = 1'b0;
    rst_n    = 1'b0;
    tick();
    check("midrst_core_rst_n", core_rst_n, 1'b0);
    check("midrst_core_en", core_en, 1'b0);
    check("midrst_running_off", running, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_timeout", timeout, 1'b0);
    check("midrst_count0", cycle_count, 0);
    check("midrst_final_pc", final_pc, 0);
    rst_n = 1'b1;
    idle_inputs();
    for (int i = 0; i < RESET_HOLD + 2; i++) tick();
    check("midrst_idle", running, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
